// File: rtl/uart_rx_fsm_pkg.sv
// Shared definitions for the UART receiver control FSM: default widths,
// state encoding, the check-point offset and the enable-vector decode.
package uart_rx_fsm_pkg;

    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_PRESC_W = 6;

    // Checkers register their flags at (prescale>>1)+2, so the flag is readable one edge later.
    localparam int unsigned CHK_OFS = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    typedef struct packed {
        logic cnt_en;
        logic samp_en;
        logic deser_en;
        logic strt_chk_en;
        logic par_chk_en;
        logic stp_chk_en;
    } rx_en_t;

    // Moore decode of the datapath enables from the current state.
    function automatic rx_en_t decode_en(input state_e s);
        rx_en_t en;
        en = '0;
        case (s)
            ST_START: begin
                en.cnt_en      = 1'b1;
                en.samp_en     = 1'b1;
                en.strt_chk_en = 1'b1;
            end
            ST_DATA: begin
                en.cnt_en   = 1'b1;
                en.samp_en  = 1'b1;
                en.deser_en = 1'b1;
            end
            ST_PARITY: begin
                en.cnt_en     = 1'b1;
                en.samp_en    = 1'b1;
                en.par_chk_en = 1'b1;
            end
            ST_STOP: begin
                en.cnt_en     = 1'b1;
                en.samp_en    = 1'b1;
                en.stp_chk_en = 1'b1;
            end
            default: ;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM. Sequences start, DATA_W data bits, optional
// parity and stop; drives the counter/sampler/deserializer/checker enables
// and reports each completed frame as data_valid (clean) or rx_err (bad).
// Ports:
//   clk, rstn                  clock, async active-low reset
//   rx_in, par_en              serial line (idle high), parity-present select
//   prescale, edge_count       oversampling ratio and position within the bit
//   bit_count                  bit index within the frame
//   start_glitch/par_err/stop_err  registered checker flags
//   cnt_en..stp_chk_en         Moore enables for the datapath blocks
//   data_valid, rx_err         registered one-cycle frame status pulses
module uart_rx_fsm
    import uart_rx_fsm_pkg::*;
#(
    parameter  int unsigned DATA_W  = DEF_DATA_W,
    parameter  int unsigned PRESC_W = DEF_PRESC_W,
    localparam int unsigned BIT_W   = $clog2(DATA_W + 3)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               rx_in,
    input  logic               par_en,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [PRESC_W-1:0] edge_count,
    input  logic [BIT_W-1:0]   bit_count,
    input  logic               start_glitch,
    input  logic               par_err,
    input  logic               stop_err,
    output logic               cnt_en,
    output logic               samp_en,
    output logic               deser_en,
    output logic               strt_chk_en,
    output logic               par_chk_en,
    output logic               stp_chk_en,
    output logic               data_valid,
    output logic               rx_err
);

    state_e state_q, state_d;
    logic   par_en_q, par_en_d;
    logic   err_flag_q, err_flag_d;
    logic   stop_err_seen_q, stop_err_seen_d;
    logic   data_valid_q, data_valid_d;
    logic   rx_err_q, rx_err_d;

    logic [PRESC_W-1:0] chk_edge;
    logic               at_chk;
    logic               at_eob;
    logic               fe;
    rx_en_t             en;

    // Check point and end-of-bit strobes; at prescale 8 both fire together.
    assign chk_edge = (prescale >> 1) + PRESC_W'(CHK_OFS);
    assign at_chk   = (edge_count == chk_edge);
    assign at_eob   = (edge_count == (prescale - PRESC_W'(1)));

    // State and status registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= ST_IDLE;
            par_en_q        <= 1'b0;
            err_flag_q      <= 1'b0;
            stop_err_seen_q <= 1'b0;
            data_valid_q    <= 1'b0;
            rx_err_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            par_en_q        <= par_en_d;
            err_flag_q      <= err_flag_d;
            stop_err_seen_q <= stop_err_seen_d;
            data_valid_q    <= data_valid_d;
            rx_err_q        <= rx_err_d;
        end
    end

    // Next-state and frame status logic.
    always_comb begin
        state_d         = state_q;
        par_en_d        = par_en_q;
        err_flag_d      = err_flag_q;
        stop_err_seen_d = stop_err_seen_q;
        data_valid_d    = 1'b0;
        rx_err_d        = 1'b0;
        fe              = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rx_in) begin
                    state_d         = ST_START;
                    par_en_d        = par_en;
                    err_flag_d      = 1'b0;
                    stop_err_seen_d = 1'b0;
                end
            end
            ST_START: begin
                // Glitch abort wins even when the check point is also end of bit.
                if (at_chk && start_glitch) begin
                    state_d = ST_IDLE;
                end else if (at_eob) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (at_eob && (bit_count == BIT_W'(DATA_W))) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (at_chk) begin
                    err_flag_d = err_flag_q | par_err;
                end
                if (at_eob) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (at_chk) begin
                    stop_err_seen_d = stop_err;
                end
                if (at_eob) begin
                    // Use the live flag when the check point coincides with end of bit.
                    fe           = err_flag_q | (at_chk ? stop_err : stop_err_seen_q);
                    data_valid_d = !fe;
                    rx_err_d     = fe;
                    if (!rx_in) begin
                        state_d         = ST_START;
                        par_en_d        = par_en;
                        err_flag_d      = 1'b0;
                        stop_err_seen_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign en          = decode_en(state_q);
    assign cnt_en      = en.cnt_en;
    assign samp_en     = en.samp_en;
    assign deser_en    = en.deser_en;
    assign strt_chk_en = en.strt_chk_en;
    assign par_chk_en  = en.par_chk_en;
    assign stp_chk_en  = en.stp_chk_en;
    assign data_valid  = data_valid_q;
    assign rx_err      = rx_err_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm. The bench plays the role of the edge/bit counter and
// the checkers, driving their outputs from the frame position, and predicts
// the enables from the bit index and the frame status from the injected errors.
module tb_uart_rx_fsm;

    logic       clk;
    logic       rstn;
    logic       rx_in;
    logic       par_en;
    logic [5:0] prescale;
    logic [5:0] edge_count;
    logic [3:0] bit_count;
    logic       start_glitch;
    logic       par_err;
    logic       stop_err;
    logic       cnt_en, samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
    logic       data_valid, rx_err;
    logic [7:0] all_o;

    int   n_chk     = 0;
    int   n_pass    = 0;
    int   n_fail    = 0;
    int   deser_cnt = 0;
    logic pend_dv   = 1'b0;
    logic pend_err  = 1'b0;

    uart_rx_fsm dut (
        .clk          (clk),
        .rstn         (rstn),
        .rx_in        (rx_in),
        .par_en       (par_en),
        .prescale     (prescale),
        .edge_count   (edge_count),
        .bit_count    (bit_count),
        .start_glitch (start_glitch),
        .par_err      (par_err),
        .stop_err     (stop_err),
        .cnt_en       (cnt_en),
        .samp_en      (samp_en),
        .deser_en     (deser_en),
        .strt_chk_en  (strt_chk_en),
        .par_chk_en   (par_chk_en),
        .stp_chk_en   (stp_chk_en),
        .data_valid   (data_valid),
        .rx_err       (rx_err)
    );

    assign all_o = {cnt_en, samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, rx_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
        n_chk++;
        assert (obs === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Expected {cnt,samp,deser,strt,par,stp} for a given bit index of a frame.
    function automatic logic [5:0] exp_en(input int b, input bit par);
        if (b == 0)                 return 6'b110100;
        else if (b <= 8)            return 6'b111000;
        else if (b == 9 && par)     return 6'b110010;
        else                        return 6'b110001;
    endfunction

    // One clock cycle: check this cycle's outputs, then drive this cycle's inputs.
    task automatic step(input logic [5:0] en_exp, input logic rx, input int e, input int b,
                        input logic g, input logic pe, input logic se, input logic pen);
        @(negedge clk);
        chk("enables", 16'({cnt_en, samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en}), 16'(en_exp));
        chk("data_valid", 16'(data_valid), 16'(pend_dv));
        chk("rx_err", 16'(rx_err), 16'(pend_err));
        pend_dv  = 1'b0;
        pend_err = 1'b0;
        if (deser_en) deser_cnt++;
        rx_in        = rx;
        edge_count   = 6'(e);
        bit_count    = 4'(b);
        start_glitch = g;
        par_err      = pe;
        stop_err     = se;
        par_en       = pen;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(6'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    // One full frame; errors appear on the checker flags only at the check edge.
    task automatic frame(input int p, input bit par, input logic [7:0] d, input bit inj_par,
                         input bit inj_stop, input bit b2b_in, input bit b2b_out, input bit next_par);
        int          nb;
        int          chkp;
        logic [10:0] bits;
        bit          fe;
        nb   = par ? 11 : 10;
        chkp = p / 2 + 3;
        bits = {1'b1, (par ? ^d : 1'b1), d, 1'b0};
        if (!b2b_in) begin
            idle(1);
            prescale = 6'(p);
            idle(1 + int'($urandom_range(0, 3)));
            step(6'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'(par));
        end
        deser_cnt = 0;
        for (int t = 0; t < nb * p; t++) begin
            int   b;
            int   e;
            logic rx;
            logic pen;
            b   = t / p;
            e   = t % p;
            rx  = bits[b];
            pen = 1'($urandom_range(0, 1));
            if (t == nb * p - 1) begin
                pen = next_par;
                if (b2b_out) rx = 1'b0;
            end
            step(exp_en(b, par), rx, e, b, 1'b0,
                 1'(inj_par && par && b == 9 && e == chkp),
                 1'(inj_stop && b == nb - 1 && e == chkp), pen);
        end
        chk("deser_cycles", 16'(deser_cnt), 16'(8 * p));
        fe       = (par && inj_par) || inj_stop;
        pend_dv  = !fe;
        pend_err = fe;
    endtask

    // Short low pulse on the line flagged as a glitch at the check edge.
    task automatic glitch(input int p);
        int chkp;
        chkp = p / 2 + 3;
        idle(1);
        prescale = 6'(p);
        idle(2);
        step(6'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t <= chkp; t++)
            step(6'b110100, 1'(t >= 3), t, 0, 1'(t == chkp), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        step(6'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset asserted in the middle of data bit 4.
    task automatic reset_mid(input int p);
        idle(1);
        prescale = 6'(p);
        idle(2);
        step(6'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t <= 4 * p + p / 2; t++)
            step(exp_en(t / p, 1'b0), 1'($urandom_range(0, 1)), t % p, t / p, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 rstn = 1'b0;
        #1 chk("async_reset", 16'(all_o), 16'h0);
        @(negedge clk);
        chk("reset_hold", 16'(all_o), 16'h0);
        rstn       = 1'b1;
        rx_in      = 1'b1;
        edge_count = 6'd0;
        bit_count  = 4'd0;
        idle(4);
    endtask

    function automatic int pick_p();
        case ($urandom_range(0, 2))
            0:       return 8;
            1:       return 16;
            default: return 32;
        endcase
    endfunction

    initial begin
        int p;
        bit par;
        bit b2b_in;
        bit b2b_out;
        bit npar;

        rstn         = 1'b1;
        rx_in        = 1'b1;
        par_en       = 1'b0;
        prescale     = 6'd8;
        edge_count   = 6'd0;
        bit_count    = 4'd0;
        start_glitch = 1'b0;
        par_err      = 1'b0;
        stop_err     = 1'b0;

        #2 rstn = 1'b0;
        #1 chk("reset_state", 16'(all_o), 16'h0);
        @(negedge clk);
        rstn = 1'b1;
        idle(3);

        // Clean frame, prescale 8, no parity.
        frame(8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Start glitch abort, prescale 16.
        glitch(16);
        // Parity error reported at stop.
        frame(16, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Stop error where check edge is end of bit, then a clean frame.
        frame(8, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        frame(8, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Abort takes priority over end of bit at prescale 8.
        glitch(8);
        // Back-to-back frames.
        frame(8, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        frame(8, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        // Back-to-back: error must not leak into the following frame.
        frame(32, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        frame(32, 1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        // Stop error at prescale 16 is only visible at the check edge.
        frame(16, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // Reset mid-frame, then a clean frame.
        reset_mid(16);
        frame(16, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized frame sequence.
        p      = pick_p();
        par    = 1'($urandom_range(0, 1));
        b2b_in = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (!b2b_in && $urandom_range(0, 5) == 0) begin
                glitch(pick_p());
            end else begin
                b2b_out = ($urandom_range(0, 2) == 0);
                npar    = 1'($urandom_range(0, 1));
                frame(p, par, 8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                      b2b_in, b2b_out, npar);
                b2b_in = b2b_out;
                par    = npar;
                if (!b2b_out) p = pick_p();
            end
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
